spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Single-clock SPI mode-0 initiator that fetches 32-bit words from an MT25Q-style serial NOR flash.
- Sequence per word: assert chip select, send READ command 0x03, send a 24-bit address, shift in 32 data bits, then release chip select.
- Sits between a simple request/response port, such as a boot ROM or XIP fetch unit, and the board-level SPI flash pins.

Parameters:
- CLK_DIV, 2, SCLK half-period in io_clk cycles; legal range 1..255.
- CS_GAP, 4, minimum io_clk cycles io_spi_ss stays high between transfers; legal range 1..255.

Ports:
- io_clk  input  1  system clock; all logic is clocked on its rising edge.
- io_rst_n  input  1  asynchronous, active-low reset.
- io_req_valid  input  1  read request present.
- io_req_ready  output  1  block idle and able to accept a request.
- io_req_addr  input  24  flash byte address, sent MSB first.
- io_rsp_valid  output  1  one-cycle pulse; io_rsp_data is valid in that cycle.
- io_rsp_data  output  32  fetched word.
- io_spi_sclk  output  1  SPI clock; idles low.
- io_spi_mosi  output  1  serial data to flash.
- io_spi_miso  input  1  serial data from flash.
- io_spi_ss  output  1  chip select, active low.

Behaviour:
- Reset (async, io_rst_n=0): every register clears immediately.
  - io_spi_ss=1, io_spi_sclk=0, io_spi_mosi=0.
  - io_req_ready=1, io_rsp_valid=0, io_rsp_data=0.
  - FSM state = IDLE.
  - Reset asserted mid-transfer aborts it: no response is issued and SS rises at once.
- FSM states: IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> GAP -> IDLE.
- IDLE:
  - io_req_ready=1.
  - A handshake occurs when io_req_valid=1 in this state (cycle T).
  - On handshake: latch io_req_addr, load the 8-bit shift register with the command, move to CMD.
  - io_req_ready=0 in all other states; requests there are ignored, not queued.
- Bit timing:
  - At T+1: io_spi_ss=0, io_spi_sclk=0, io_spi_mosi = command bit 7.
  - A half-period counter toggles io_spi_sclk every CLK_DIV cycles.
  - Rising edge: io_spi_miso is sampled in the same io_clk cycle that sclk is driven high.
  - Falling edge: the next MOSI bit is driven in the same io_clk cycle that sclk is driven low.
- Bit counts, all MSB first on MOSI:
  - CMD: 8 bits.
  - ADDR: 24 bits.
  - DATA: 32 bits sampled; MOSI is held 0 during DATA.
  - The state advances on the falling edge that follows the last rising edge of the field.
- Data assembly:
  - Each byte is received MSB first.
  - Byte 0 (first received) lands in io_rsp_data[7:0], byte 1 in [15:8], byte 2 in [23:16], byte 3 in [31:24] (little-endian word).
- Completion:
  - After the 64th rising edge (default build), wait CLK_DIV cycles.
  - In one cycle: drive sclk low and io_spi_ss=1, update io_rsp_data, pulse io_rsp_valid for exactly one cycle.
- Latency: io_rsp_valid rises at T+1+128*CLK_DIV; for CLK_DIV=2 that is T+257.
- io_rsp_data holds its value until the next completion.
- GAP: SS stays high for CS_GAP cycles after completion, then the FSM returns to IDLE with io_req_ready=1.
- There is no response backpressure; the consumer must accept the pulse.
- Counter wrap: all counters are sized for their maximum value and return to 0 at each state change.
- CLK_DIV=1: sclk toggles every cycle; sampling and shifting rules are unchanged.

Optional Feature:
- Macro: SPI_FLASH_READER_FAST_READ_EN.
- Defined:
  - Command is 0x0B (FAST READ).
  - A DUMMY state follows ADDR: 8 sclk periods with MOSI=0 and MISO ignored.
  - Latency becomes T+1+144*CLK_DIV.
- Undefined:
  - Command is 0x03.
  - The DUMMY state and its counter are not compiled in.

Test Plan:
- Reset values: hold io_rst_n=0 -> ss=1, sclk=0, mosi=0, ready=1, rsp_valid=0, rsp_data=0.
- Single read: CLK_DIV=2, addr 0x000010, flash model returns bytes 0x11,0x22,0x33,0x44.
  - MOSI shows 0x03 then 0x000010.
  - rsp_valid pulses at T+257 with rsp_data=0x44332211.
  - Exactly 64 sclk rising edges occur.
- Back-to-back: hold req_valid=1 for two requests.
  - Second handshake occurs only after SS has been high for 4 cycles.
  - Two rsp pulses arrive, each with correct data.
  - Requests presented while busy are ignored.
- Reset mid-transfer: drop io_rst_n during the ADDR bit 12 period.
  - SS goes high asynchronously and no rsp_valid is issued.
  - After release, a new read of 0x000020 completes correctly.
- CLK_DIV=1 with addr 0xFFFFFC: sclk toggles every cycle, MOSI shows 0xFFFFFC, and data matches the flash model.
- With SPI_FLASH_READER_FAST_READ_EN defined, CLK_DIV=2:
  - MOSI shows 0x0B, the address, then 8 dummy zero bits.
  - rsp_valid pulses at T+289.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI mode-0 initiator that reads one 32-bit little-endian word per request from a serial NOR flash.
// Define SPI_FLASH_READER_FAST_READ_EN to issue FAST READ (0x0B) with an 8-clock dummy phase.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        io_clk,
  input  logic        io_rst_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [23:0] io_req_addr,
  output logic        io_rsp_valid,
  output logic [31:0] io_rsp_data,
  output logic        io_spi_sclk,
  output logic        io_spi_mosi,
  input  logic        io_spi_miso,
  output logic        io_spi_ss
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_e;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_e;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic [30:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [5:0]  field_bits;

  always_comb begin
    case (state_q)
      CMD:     field_bits = 6'd8;
      ADDR:    field_bits = 6'd24;
`ifdef SPI_FLASH_READER_FAST_READ_EN
      DUMMY:   field_bits = 6'd8;
`endif
      default: field_bits = 6'd32;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_req_valid) begin
          // Command MSB goes straight to MOSI; the rest of command and address queue behind it.
          state_d = CMD;
          tx_d    = {READ_CMD[6:0], io_req_addr};
          mosi_d  = READ_CMD[7];
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 6'd1;
            if (state_q == DATA) rx_d = {rx_q[30:0], io_spi_miso};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[29:0], 1'b0};
            mosi_d = 1'b0;
            if (state_q == CMD || (state_q == ADDR && bit_q != field_bits)) mosi_d = tx_q[30];
            if (bit_q == field_bits) begin
              bit_d = '0;
              case (state_q)
                CMD:  state_d = ADDR;
`ifdef SPI_FLASH_READER_FAST_READ_EN
                ADDR:  state_d = DUMMY;
                DUMMY: state_d = DATA;
`else
                ADDR: state_d = DATA;
`endif
                DATA: begin
                  // First byte received is the least significant byte of the word.
                  state_d     = GAP;
                  ss_d        = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                end
                default: begin
                  state_d = IDLE;
                  ss_d    = 1'b1;
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign io_req_ready = (state_q == IDLE);
  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_data  = rsp_data_q;
  assign io_spi_sclk  = sclk_q;
  assign io_spi_mosi  = mosi_q;
  assign io_spi_ss    = ss_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) talking to a behavioural flash.
// Honours SPI_FLASH_READER_FAST_READ_EN for command, header length and latency.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int HDR = 40;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int HDR = 32;
`endif
  localparam int CS_GAP = 4;
  localparam int HALVES = 2 * (HDR + 32);

  typedef struct {
    int          inst;
    logic [23:0] addr;
    logic [31:0] exp;
  } vec_t;

  logic        io_clk = 1'b0;
  logic [1:0]  rst_n, req_valid, req_ready, rsp_valid;
  logic [1:0]  spi_sclk, spi_mosi, spi_ss;
  logic [1:0]  spi_miso = 2'b00;
  logic [23:0] req_addr [2];
  logic [31:0] rsp_data [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 io_clk = ~io_clk;
  always @(posedge io_clk) cyc <= cyc + 1;

  spi_flash_reader #(.CLK_DIV(2), .CS_GAP(CS_GAP)) u_div2 (
    .io_clk(io_clk), .io_rst_n(rst_n[0]),
    .io_req_valid(req_valid[0]), .io_req_ready(req_ready[0]), .io_req_addr(req_addr[0]),
    .io_rsp_valid(rsp_valid[0]), .io_rsp_data(rsp_data[0]),
    .io_spi_sclk(spi_sclk[0]), .io_spi_mosi(spi_mosi[0]), .io_spi_miso(spi_miso[0]), .io_spi_ss(spi_ss[0])
  );

  spi_flash_reader #(.CLK_DIV(1), .CS_GAP(CS_GAP)) u_div1 (
    .io_clk(io_clk), .io_rst_n(rst_n[1]),
    .io_req_valid(req_valid[1]), .io_req_ready(req_ready[1]), .io_req_addr(req_addr[1]),
    .io_rsp_valid(rsp_valid[1]), .io_rsp_data(rsp_data[1]),
    .io_spi_sclk(spi_sclk[1]), .io_spi_mosi(spi_mosi[1]), .io_spi_miso(spi_miso[1]), .io_spi_ss(spi_ss[1])
  );

  // Flash contents: 0x10..0x13 hold 11,22,33,44; elsewhere a hash of the address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] n;
    if (a[23:2] == 22'd4) begin
      n = {6'd0, a[1:0]} + 8'd1;
      return n * 8'd17;
    end
    return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[23:16] * 8'd3) ^ 8'h5A;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Behavioural flash: counts SCLK rises while selected, records the header, serves data bits.
  int          fl_rises [2];
  int          last_rises [2];
  logic [39:0] fl_hdr [2];
  logic [39:0] last_hdr [2];
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_ss = 2'b11;
  int          fl_idx;
  logic [23:0] fl_a;
  logic [7:0]  fl_b;

  always @(spi_sclk or spi_ss) begin
    for (int i = 0; i < 2; i++) begin
      if (spi_ss[i] === 1'b1) begin
        if (prev_ss[i] !== 1'b1) begin
          last_rises[i] = fl_rises[i];
          last_hdr[i]   = fl_hdr[i];
        end
        fl_rises[i] = 0;
        fl_hdr[i]   = '0;
        spi_miso[i] = 1'b0;
      end else if (spi_sclk[i] && !prev_sclk[i]) begin
        if (fl_rises[i] < HDR) fl_hdr[i] = {fl_hdr[i][38:0], spi_mosi[i]};
        fl_rises[i] = fl_rises[i] + 1;
      end else if (!spi_sclk[i] && prev_sclk[i]) begin
        if (fl_rises[i] >= HDR && fl_rises[i] < HDR + 32) begin
          fl_idx = fl_rises[i] - HDR;
          fl_a   = 24'(fl_hdr[i] >> (HDR - 32));
          fl_b   = flash_byte(fl_a + 24'(fl_idx / 8));
          spi_miso[i] = fl_b[7 - (fl_idx % 8)];
        end else begin
          spi_miso[i] = 1'b0;
        end
      end
      prev_sclk[i] = spi_sclk[i];
      prev_ss[i]   = spi_ss[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int k;
    k = 0;
    while (req_ready[i] !== 1'b1 && k < 2000) begin
      @(negedge io_clk);
      k++;
    end
    chk("ready_wait", req_ready[i], 1'b1);
  endtask

  task automatic do_read(input int i, input logic [23:0] addr, input logic [31:0] exp);
    int  t0, tr;
    bit  got;
    logic [31:0] data;
    wait_ready(i);
    req_addr[i]  = addr;
    req_valid[i] = 1'b1;
    t0 = cyc;
    @(negedge io_clk);
    req_valid[i] = 1'b0;
    chk("ss_low_t1", spi_ss[i], 1'b0);
    chk("sclk_low_t1", spi_sclk[i], 1'b0);
    chk("mosi_cmd7_t1", spi_mosi[i], CMD[7]);
    got = 0;
    tr  = 0;
    data = '0;
    for (int k = 0; k < 4000 && !got; k++) begin
      if (rsp_valid[i] === 1'b1) begin
        got  = 1;
        tr   = cyc;
        data = rsp_data[i];
      end else begin
        @(negedge io_clk);
      end
    end
    chk("rsp_seen", got, 1'b1);
    chk("latency", tr - t0, 1 + HALVES * div_of(i));
    chk("rsp_data", data, exp);
    chk("sclk_rises", last_rises[i], HDR + 32);
    chk("mosi_header", last_hdr[i], 40'({CMD, addr}) << (HDR - 32));
    @(negedge io_clk);
    chk("rsp_pulse_width", rsp_valid[i], 1'b0);
    chk("rsp_data_hold", rsp_data[i], exp);
    $display("read inst=%0d div=%0d addr=%06h data=%08h latency=%0d", i, div_of(i), addr, data, tr - t0);
  endtask

  task automatic back_to_back(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    int hs, rs;
    int hs_cyc [2];
    int rs_cyc [2];
    logic [31:0] rs_dat [2];
    bit pend;
    hs = 0; rs = 0; pend = 0;
    hs_cyc = '{0, 0}; rs_cyc = '{0, 0}; rs_dat = '{32'h0, 32'h0};
    wait_ready(0);
    req_addr[0]  = a;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 3000 && rs < 2; k++) begin
      if (pend) begin
        req_addr[0] = (hs == 1) ? b : c;
        pend = 0;
      end
      if (req_ready[0] && req_valid[0]) begin
        if (hs < 2) hs_cyc[hs] = cyc;
        hs++;
        pend = 1;
      end
      if (rsp_valid[0] === 1'b1) begin
        if (rs < 2) begin
          rs_cyc[rs] = cyc;
          rs_dat[rs] = rsp_data[0];
        end
        rs++;
      end
      if (rs < 2) @(negedge io_clk);
    end
    req_valid[0] = 1'b0;
    chk("b2b_handshakes", hs, 2);
    chk("b2b_responses", rs, 2);
    chk("b2b_data0", rs_dat[0], ref_word(a));
    chk("b2b_data1", rs_dat[1], ref_word(b));
    chk("b2b_latency0", rs_cyc[0] - hs_cyc[0], 1 + HALVES * 2);
    chk("b2b_gap", hs_cyc[1] - rs_cyc[0], CS_GAP);
    repeat (20) @(negedge io_clk);
    chk("b2b_no_third_ss", spi_ss[0], 1'b1);
    chk("b2b_idle_ready", req_ready[0], 1'b1);
    $display("back-to-back addr=%06h,%06h data=%08h,%08h gap=%0d", a, b, rs_dat[0], rs_dat[1], hs_cyc[1] - rs_cyc[0]);
  endtask

  task automatic abort_read();
    int k;
    bit seen;
    seen = 0;
    wait_ready(0);
    req_addr[0]  = 24'h123456;
    req_valid[0] = 1'b1;
    @(negedge io_clk);
    req_valid[0] = 1'b0;
    k = 0;
    while (fl_rises[0] < 20 && k < 1000) begin
      @(negedge io_clk);
      k++;
    end
    chk("abort_reached_addr12", fl_rises[0], 20);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("abort_ss_async", spi_ss[0], 1'b1);
    chk("abort_sclk_async", spi_sclk[0], 1'b0);
    chk("abort_ready_async", req_ready[0], 1'b1);
    repeat (5) begin
      @(negedge io_clk);
      if (rsp_valid[0] === 1'b1) seen = 1;
    end
    rst_n[0] = 1'b1;
    repeat (300) begin
      @(negedge io_clk);
      if (rsp_valid[0] === 1'b1 || spi_ss[0] !== 1'b1) seen = 1;
    end
    chk("abort_no_rsp", seen, 1'b0);
    $display("abort during address bit 12, ss=%0b after reset", spi_ss[0]);
    do_read(0, 24'h000020, ref_word(24'h000020));
  endtask

  initial begin
    vec_t tbl [5];
    int          ri;
    logic [23:0] ra;

    rst_n     = 2'b00;
    req_valid = 2'b00;
    req_addr  = '{24'h0, 24'h0};
    repeat (3) @(negedge io_clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ss", spi_ss[i], 1'b1);
      chk("rst_sclk", spi_sclk[i], 1'b0);
      chk("rst_mosi", spi_mosi[i], 1'b0);
      chk("rst_ready", req_ready[i], 1'b1);
      chk("rst_rsp_valid", rsp_valid[i], 1'b0);
      chk("rst_rsp_data", rsp_data[i], 32'h0);
    end
    $display("reset state checked on both instances");
    rst_n = 2'b11;
    @(negedge io_clk);

    tbl[0] = '{0, 24'h000010, 32'h44332211};
    tbl[1] = '{1, 24'hFFFFFC, ref_word(24'hFFFFFC)};
    tbl[2] = '{0, 24'hFFFFFE, ref_word(24'hFFFFFE)};
    tbl[3] = '{1, 24'h000010, 32'h44332211};
    tbl[4] = '{0, 24'hA5A5A5, ref_word(24'hA5A5A5)};
    for (int v = 0; v < 5; v++) do_read(tbl[v].inst, tbl[v].addr, tbl[v].exp);

    back_to_back(24'h000010, 24'h00ABCD, 24'h777777);
    abort_read();

    for (int n = 0; n < 14; n++) begin
      ri = int'($urandom_range(0, 1));
      ra = 24'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge io_clk);
      do_read(ri, ra, ref_word(ra));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
